// File: rtl/mspe_pkg.sv
// Shared types, constants and the round-robin pick helper for the MSPE dispatch path.
package mspe_pkg;

  localparam int MSPE_DATA_W    = 512;
  localparam int MSPE_MAX_CORES = 32;

  typedef enum logic [0:0] {DSP_IDLE, DSP_FORWARD} dsp_state_t;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // Index of the first set bit of mask[n-1:0] at or after ptr, wrapping at n.
  // Offsets are walked from highest to lowest so the nearest hit is written last.
  function automatic rr_pick_t rr_pick(input logic [31:0] mask, input logic [4:0] ptr, input int n);
    rr_pick_t res;
    int       j;
    res = '0;
    for (int k = MSPE_MAX_CORES - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (mask[j[4:0]]) begin
          res.found = 1'b1;
          res.idx   = j[4:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mspe_snk_dispatch_if.sv
// Sink stream in, shared core write bus out. The dispatcher sits on the slave side.
interface mspe_snk_dispatch_if
  import mspe_pkg::*;
#(
  parameter int CORES  = 4,
  parameter int DATA_W = MSPE_DATA_W
);
  logic [DATA_W-1:0] snk_data;
  logic              snk_valid;
  logic              snk_sop;
  logic              snk_eop;
  logic              snk_ready;

  logic [DATA_W-1:0] core_data;
  logic [CORES-1:0]  core_we;
  logic              core_eop;

  modport master (
    output snk_data, snk_valid, snk_sop, snk_eop,
    input  snk_ready,
    input  core_data, core_we, core_eop
  );

  modport slave (
    input  snk_data, snk_valid, snk_sop, snk_eop,
    output snk_ready,
    output core_data, core_we, core_eop
  );
endinterface

// File: rtl/mspe_rr_pick.sv
// Combinational round-robin picker: first set bit of i_mask starting at i_ptr.
module mspe_rr_pick
  import mspe_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_mask,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);
  rr_pick_t w_res;

  assign w_res   = rr_pick(32'(i_mask), 5'(i_ptr), N);
  assign o_found = w_res.found;
  assign o_idx   = IDX_W'(w_res.idx);
endmodule

// File: rtl/mspe_snk_dispatch.sv
// Packet dispatcher: steers each whole sink packet to one core FIFO, round-robin
// over enabled, not-full cores. One bubble per packet for target selection.
module mspe_snk_dispatch
  import mspe_pkg::*;
#(
  parameter int CORES  = 4,
  parameter int DATA_W = MSPE_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  mspe_snk_dispatch_if.slave bus,
  input  logic [CORES-1:0] core_en,
  input  logic [CORES-1:0] core_full,
  output logic [4:0]       cur_core,
  output logic             busy,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] pkt_count
);
  localparam int IDX_W = (CORES > 1) ? $clog2(CORES) : 1;

  dsp_state_t        r_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_sel;
  logic              r_first;
  logic [CORES-1:0]  r_core_we;
  logic [DATA_W-1:0] r_core_data;
  logic              r_core_eop;
  logic [CNT_W-1:0]  r_drop;
  logic [CNT_W-1:0]  r_err;
  logic [CNT_W-1:0]  r_pkt;

  logic [CORES-1:0]  w_elig;
  logic [CORES-1:0]  w_sel_onehot;
  logic              w_found;
  logic [IDX_W-1:0]  w_pick;
  logic              w_ready;
  logic              w_accept;
  logic [IDX_W-1:0]  w_rr_next;

  assign w_elig = core_en & ~core_full;

  mspe_rr_pick #(
    .N     (CORES),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_mask  (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  // One-hot write strobe for the core currently owning the packet.
  generate
    for (genvar gi = 0; gi < CORES; gi++) begin : g_onehot
      assign w_sel_onehot[gi] = (r_sel == IDX_W'(gi));
    end
  endgenerate

  // Next round-robin start: the core after the one that just finished.
  assign w_rr_next = (r_sel == IDX_W'(CORES - 1)) ? '0 : r_sel + IDX_W'(1);

  // Sink ready: idle drops non-sop beats; forwarding follows the target's full flag.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      DSP_IDLE:    w_ready = bus.snk_valid & ~bus.snk_sop;
      DSP_FORWARD: w_ready = ~core_full[r_sel];
      default:     w_ready = 1'b0;
    endcase
  end

  assign w_accept = bus.snk_valid & w_ready;

  // Dispatch FSM with registered write bus and saturating status counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= DSP_IDLE;
      r_rr_ptr    <= '0;
      r_sel       <= '0;
      r_first     <= 1'b0;
      r_core_we   <= '0;
      r_core_data <= '0;
      r_core_eop  <= 1'b0;
      r_drop      <= '0;
      r_err       <= '0;
      r_pkt       <= '0;
    end else begin
      r_core_we  <= '0;
      r_core_eop <= 1'b0;
      case (r_state)
        DSP_IDLE: begin
          if (bus.snk_valid && !bus.snk_sop) begin
            if (~&r_drop) r_drop <= r_drop + CNT_W'(1);
          end else if (bus.snk_valid && w_found) begin
            r_sel   <= w_pick;
            r_first <= 1'b1;
            r_state <= DSP_FORWARD;
          end
        end
        DSP_FORWARD: begin
          if (w_accept) begin
            r_core_we   <= w_sel_onehot;
            r_core_data <= bus.snk_data;
            r_core_eop  <= bus.snk_eop;
            r_first     <= 1'b0;
            // A sop inside a packet is a protocol error but still carried as data.
            if (bus.snk_sop && !r_first && (~&r_err)) r_err <= r_err + CNT_W'(1);
            if (bus.snk_eop) begin
              if (~&r_pkt) r_pkt <= r_pkt + CNT_W'(1);
              r_rr_ptr <= w_rr_next;
              r_state  <= DSP_IDLE;
            end
          end
        end
        default: r_state <= DSP_IDLE;
      endcase
    end
  end

  assign bus.snk_ready = w_ready;
  assign bus.core_we   = r_core_we;
  assign bus.core_data = r_core_data;
  assign bus.core_eop  = r_core_eop;
  assign cur_core      = 5'(r_sel);
  assign busy          = (r_state == DSP_FORWARD);
  assign drop_count    = r_drop;
  assign err_count     = r_err;
  assign pkt_count     = r_pkt;
endmodule
